// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch stage of the 8-bit CPU.
//
// State table:
//   S_IDLE | after reset, no request; moves to S_REQ on the next edge
//   S_REQ  | IMEM_READ high, waiting for I_BUSYWAIT low to capture INSTR_IN
//   S_EXEC | INSTRUCTION valid for decode; PC advances when D_BUSYWAIT is low
//   2'b11  | unreachable, recovers to S_IDLE
//
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   TARGET             branch/jump target (low two bits ignored)
//   BRANCH_TAKEN       selects TARGET instead of PC+4 when leaving S_EXEC
//   D_BUSYWAIT         data-memory stall, freezes S_EXEC
//   I_BUSYWAIT         instruction-memory busy, INSTR_IN valid when low
//   INSTR_IN           instruction word from instruction memory
//   IMEM_READ          read request (decoded from state)
//   IMEM_ADDRESS       read address, always the PC
//   PC, PC_PLUS4       program counter and its sequential successor
//   INSTRUCTION        registered instruction presented to decode
//   INSTR_VALID        high while INSTRUCTION is executing
//   RETIRED            count of completed instructions, wraps at 2^32
//   FETCH_ERR          sticky fetch-timeout flag, cleared only by reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] TARGET,
    input  logic        BRANCH_TAKEN,
    input  logic        D_BUSYWAIT,
    input  logic        I_BUSYWAIT,
    input  logic [31:0] INSTR_IN,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID,
    output logic [31:0] RETIRED,
    output logic        FETCH_ERR
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_REQ  = 2'b01;
    localparam logic [1:0] S_EXEC = 2'b10;

    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    logic [31:0] next_pc;

    assign PC_PLUS4     = PC + 32'd4;
    assign IMEM_READ    = (state == S_REQ);
    assign IMEM_ADDRESS = PC;

    // Saturate so a memory that never answers cannot wrap the counter
    // back below the timeout threshold.
    assign wait_cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    // Targets are word aligned by construction.
    assign next_pc = BRANCH_TAKEN ? {TARGET[31:2], 2'b00} : PC_PLUS4;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            INSTRUCTION <= '0;
            INSTR_VALID <= 1'b0;
            RETIRED     <= '0;
            FETCH_ERR   <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (!I_BUSYWAIT) begin
                        INSTRUCTION <= INSTR_IN;
                        INSTR_VALID <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= S_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        // Flag only; the fetch keeps waiting for memory.
                        if (TIMEOUT_EN && (wait_cnt_inc >= TIMEOUT_W)) begin
                            FETCH_ERR <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    // A stalled edge ignores BRANCH_TAKEN/TARGET entirely;
                    // the branch is re-evaluated on the releasing edge.
                    if (!D_BUSYWAIT) begin
                        PC          <= next_pc;
                        RETIRED     <= RETIRED + 32'd1;
                        INSTR_VALID <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    INSTR_VALID <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: table-driven cycle vectors plus directed
// sequences for fetch wait, timeout, reset mid-fetch and PC wrap.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] target;
    logic        branch_taken;
    logic        d_busywait;
    logic        i_busywait;
    logic [31:0] instr_in;

    logic        imem_read,   imem_read2;
    logic [31:0] imem_addr,   imem_addr2;
    logic [31:0] pc,          pc2;
    logic [31:0] pc_plus4,    pc_plus4_2;
    logic [31:0] instruction, instruction2;
    logic        instr_valid, instr_valid2;
    logic [31:0] retired,     retired2;
    logic        fetch_err,   fetch_err2;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .CLK(clk), .RESET(reset), .TARGET(target), .BRANCH_TAKEN(branch_taken),
        .D_BUSYWAIT(d_busywait), .I_BUSYWAIT(i_busywait), .INSTR_IN(instr_in),
        .IMEM_READ(imem_read), .IMEM_ADDRESS(imem_addr), .PC(pc),
        .PC_PLUS4(pc_plus4), .INSTRUCTION(instruction), .INSTR_VALID(instr_valid),
        .RETIRED(retired), .FETCH_ERR(fetch_err)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
        .CLK(clk), .RESET(reset), .TARGET(target), .BRANCH_TAKEN(branch_taken),
        .D_BUSYWAIT(d_busywait), .I_BUSYWAIT(i_busywait), .INSTR_IN(instr_in),
        .IMEM_READ(imem_read2), .IMEM_ADDRESS(imem_addr2), .PC(pc2),
        .PC_PLUS4(pc_plus4_2), .INSTRUCTION(instruction2), .INSTR_VALID(instr_valid2),
        .RETIRED(retired2), .FETCH_ERR(fetch_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ib;
        logic        db;
        logic        tk;
        logic [31:0] tg;
        logic [31:0] in;
        logic        rd;
        logic        iv;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ret;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic ib, logic db, logic tk, logic [31:0] tg,
                                logic [31:0] in, logic rd, logic iv,
                                logic [31:0] addr, logic [31:0] instr,
                                logic [31:0] ret);
        vec_t v;
        v.ib = ib; v.db = db; v.tk = tk; v.tg = tg; v.in = in;
        v.rd = rd; v.iv = iv; v.addr = addr; v.instr = instr; v.ret = ret;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, then sample 1 time unit after the next rising edge.
    task automatic step(input logic rst, input logic ib, input logic db,
                        input logic tk, input logic [31:0] tg,
                        input logic [31:0] in);
        reset = rst; i_busywait = ib; d_busywait = db;
        branch_taken = tk; target = tg; instr_in = in;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Each vector starts from the state left by the previous one; the first
        // starts in S_IDLE just after reset.
        vecs[0]  = mk(0, 0, 0, 32'h0,   32'hA0A0_A0A0, 1, 0, 32'h00, 32'h0,         0);
        vecs[1]  = mk(0, 0, 0, 32'h0,   32'h1111_1111, 0, 1, 32'h00, 32'h1111_1111, 0);
        vecs[2]  = mk(0, 0, 0, 32'h0,   32'hBAD0_0001, 1, 0, 32'h04, 32'h1111_1111, 1);
        vecs[3]  = mk(0, 0, 0, 32'h0,   32'h2222_2222, 0, 1, 32'h04, 32'h2222_2222, 1);
        vecs[4]  = mk(0, 0, 0, 32'h0,   32'hBAD0_0002, 1, 0, 32'h08, 32'h2222_2222, 2);
        vecs[5]  = mk(0, 0, 0, 32'h0,   32'h3333_3333, 0, 1, 32'h08, 32'h3333_3333, 2);
        vecs[6]  = mk(0, 0, 0, 32'h0,   32'hBAD0_0003, 1, 0, 32'h0C, 32'h3333_3333, 3);
        vecs[7]  = mk(0, 0, 0, 32'h0,   32'h4444_4444, 0, 1, 32'h0C, 32'h4444_4444, 3);
        vecs[8]  = mk(0, 0, 0, 32'h0,   32'hBAD0_0004, 1, 0, 32'h10, 32'h4444_4444, 4);
        vecs[9]  = mk(0, 0, 0, 32'h0,   32'h5555_5555, 0, 1, 32'h10, 32'h5555_5555, 4);
        // taken branch with misaligned target: low bits dropped
        vecs[10] = mk(0, 0, 1, 32'h43,  32'hBAD0_0005, 1, 0, 32'h40, 32'h5555_5555, 5);
        vecs[11] = mk(0, 0, 0, 32'h0,   32'h6666_6666, 0, 1, 32'h40, 32'h6666_6666, 5);
        vecs[12] = mk(0, 0, 1, 32'h10,  32'hBAD0_0006, 1, 0, 32'h10, 32'h6666_6666, 6);
        vecs[13] = mk(0, 0, 0, 32'h0,   32'h7777_7777, 0, 1, 32'h10, 32'h7777_7777, 6);
        // not taken: sequential despite a TARGET being present
        vecs[14] = mk(0, 0, 0, 32'h80,  32'hBAD0_0007, 1, 0, 32'h14, 32'h7777_7777, 7);
        // branch inputs in S_REQ are ignored
        vecs[15] = mk(1, 0, 1, 32'h200, 32'hBAD0_0008, 1, 0, 32'h14, 32'h7777_7777, 7);
        vecs[16] = mk(0, 0, 1, 32'h200, 32'h8888_8888, 0, 1, 32'h14, 32'h8888_8888, 7);
        // data stall 4 cycles with toggling branch, then release taken to 0x80
        vecs[17] = mk(0, 1, 1, 32'h100, 32'hDEAD_0001, 0, 1, 32'h14, 32'h8888_8888, 7);
        vecs[18] = mk(0, 1, 0, 32'h104, 32'hDEAD_0002, 0, 1, 32'h14, 32'h8888_8888, 7);
        vecs[19] = mk(0, 1, 1, 32'h108, 32'hDEAD_0003, 0, 1, 32'h14, 32'h8888_8888, 7);
        vecs[20] = mk(0, 1, 0, 32'h10C, 32'hDEAD_0004, 0, 1, 32'h14, 32'h8888_8888, 7);
        vecs[21] = mk(0, 0, 1, 32'h80,  32'hBAD0_0009, 1, 0, 32'h80, 32'h8888_8888, 8);

        // reset state
        step(1, 1, 1, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        check("rst_imem_read",   {31'b0, imem_read},   0);
        check("rst_pc",          pc,                   0);
        check("rst_instruction", instruction,          0);
        check("rst_instr_valid", {31'b0, instr_valid}, 0);
        check("rst_retired",     retired,              0);
        check("rst_fetch_err",   {31'b0, fetch_err},   0);

        for (int i = 0; i < 22; i++) begin
            step(0, vecs[i].ib, vecs[i].db, vecs[i].tk, vecs[i].tg, vecs[i].in);
            check($sformatf("v%0d_imem_read", i),   {31'b0, imem_read},   {31'b0, vecs[i].rd});
            check($sformatf("v%0d_instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].iv});
            check($sformatf("v%0d_imem_address", i), imem_addr,           vecs[i].addr);
            check($sformatf("v%0d_pc", i),          pc,                   vecs[i].addr);
            check($sformatf("v%0d_pc_plus4", i),    pc_plus4,             vecs[i].addr + 32'd4);
            check($sformatf("v%0d_instruction", i), instruction,          vecs[i].instr);
            check($sformatf("v%0d_retired", i),     retired,              vecs[i].ret);
            check($sformatf("v%0d_fetch_err", i),   {31'b0, fetch_err},   0);
        end

        // instruction-memory wait of 5 cycles at PC=0x80
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 32'h0, 32'hBAD0_1000);
            check("wait5_imem_read",   {31'b0, imem_read},   1);
            check("wait5_instr_valid", {31'b0, instr_valid}, 0);
            check("wait5_fetch_err",   {31'b0, fetch_err},   0);
        end
        step(0, 0, 0, 0, 32'h0, 32'h00C0_FFEE);
        check("wait5_instruction", instruction,          32'h00C0_FFEE);
        check("wait5_valid",       {31'b0, instr_valid}, 1);
        check("wait5_err_after",   {31'b0, fetch_err},   0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("wait5_next_addr",   imem_addr, 32'h84);
        check("wait5_retired",     retired,   9);

        // 20 busy cycles: flag sets once 16 busy cycles have elapsed
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 0, 32'h0, 32'hBAD0_2000);
            if (i == 15) check("to_err_at15", {31'b0, fetch_err}, 0);
            if (i == 20) check("to_err_at20", {31'b0, fetch_err}, 1);
        end
        step(0, 0, 0, 0, 32'h0, 32'h1234_5678);
        check("to_instruction",  instruction,        32'h1234_5678);
        check("to_err_sticky1",  {31'b0, fetch_err}, 1);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("to_next_addr",    imem_addr,          32'h88);
        check("to_err_sticky2",  {31'b0, fetch_err}, 1);

        // reset mid-fetch; busywait drops in the reset cycle
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        check("rmf_err_before", {31'b0, fetch_err}, 1);
        step(1, 0, 0, 1, 32'h400, 32'hFACE_FACE);
        check("rmf_pc",          pc,                   0);
        check("rmf_instr_valid", {31'b0, instr_valid}, 0);
        check("rmf_fetch_err",   {31'b0, fetch_err},   0);
        check("rmf_instruction", instruction,          0);
        check("rmf_retired",     retired,              0);
        check("rmf_imem_read",   {31'b0, imem_read},   0);
        step(0, 1, 0, 0, 32'h0, 32'hFACE_FACE);
        check("rmf_req_read",    {31'b0, imem_read},   1);
        check("rmf_req_instr",   instruction,          0);

        // wrap instance (RESET_PC=FFFF_FFFC) was reset alongside and is in S_REQ
        check("wrap_first_addr", imem_addr2,          32'hFFFF_FFFC);
        check("wrap_pc_plus4",   pc_plus4_2,          32'h0);
        check("wrap_first_read", {31'b0, imem_read2}, 1);
        step(0, 0, 0, 0, 32'h0, 32'hCAFE_0001);
        check("wrap_instruction", instruction2,         32'hCAFE_0001);
        check("wrap_valid",       {31'b0, instr_valid2}, 1);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        check("wrap_second_addr", imem_addr2,           32'h0);
        check("wrap_retired",     retired2,             1);
        check("wrap_fetch_err",   {31'b0, fetch_err2},  0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
